airisc_wb_arbiter: RTL and testbench

Two-master to one-slave Wishbone (classic, pipelined-free) arbiter inside `user_proj_airisc`. It shares the user-area Wishbone resource between the Caravel management SoC port (master 0) and the AIRISC core data port (master 1). Grants are round-robin and locked for the whole `cyc` cycle. An optional bus watchdog terminates stalled accesses with an error.

---
 rtl/airisc_wb_arbiter_if.sv | 27 ++
 rtl/airisc_wb_arbiter.sv | 170 +++++++++++++++++
 tb/tb_airisc_wb_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/airisc_wb_arbiter_if.sv
// Wishbone classic bus bundle used on the airisc_wb_arbiter ports.
// The master modport drives a request and receives the termination,
// the slave modport is the mirror image.
interface airisc_wb_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic            cyc;
    logic            stb;
    logic            we;
    logic [DW/8-1:0] sel;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;  // master -> slave write data
    logic [DW-1:0]   dat_r;  // slave -> master read data
    logic            ack;
    logic            err;

    modport master (
        output cyc, stb, we, sel, adr, dat_w,
        input  dat_r, ack, err
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_w,
        output dat_r, ack, err
    );
endinterface

// File: rtl/airisc_wb_arbiter.sv
// airisc_wb_arbiter: two-master to one-slave Wishbone classic arbiter.
// Master 0 is the Caravel management port, master 1 the AIRISC data port.
// Round-robin grant, locked for the whole cyc of the owner. The request
// path is a pure mux of the owner, so data/ack add no latency past the grant.
// Define AIRISC_WB_ARB_TIMEOUT_EN to add a bus watchdog that errors out an
// access stalled for TIMEOUT cycles.
module airisc_wb_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    airisc_wb_arbiter_if.slave  m0_if,
    airisc_wb_arbiter_if.slave  m1_if,
    airisc_wb_arbiter_if.master s_if,
    output logic [1:0]          grant_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StGnt0 = 2'd1;
    localparam logic [1:0] StGnt1 = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            last_q, last_d;
    logic            req0, req1;
    logic            arb_en;
    logic            timeout;

    logic            own_cyc;
    logic            own_stb;
    logic            own_we;
    logic [DW/8-1:0] own_sel;
    logic [AW-1:0]   own_adr;
    logic [DW-1:0]   own_dat;

    assign req0 = m0_if.cyc & m0_if.stb;
    assign req1 = m1_if.cyc & m1_if.stb;

    // Re-arbitrate unless the current owner still holds cyc (also recovers
    // from the unused state encoding).
    assign arb_en = !((state_q == StGnt0) && m0_if.cyc) &&
                    !((state_q == StGnt1) && m1_if.cyc);

    // Round-robin next owner: on contention the master that was not last wins.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        if (arb_en) begin
            if (req0 && req1) begin
                state_d = last_q ? StGnt0 : StGnt1;
                last_d  = ~last_q;
            end else if (req0) begin
                state_d = StGnt0;
                last_d  = 1'b0;
            end else if (req1) begin
                state_d = StGnt1;
                last_d  = 1'b1;
            end else begin
                state_d = StIdle;
            end
        end
    end

    // Owner state and round-robin pointer; reset drops the bus immediately.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Forward the owner's request to the slave; idle drives zeros.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_sel = '0;
        own_adr = '0;
        own_dat = '0;
        case (state_q)
            StGnt0: begin
                own_cyc = m0_if.cyc;
                own_stb = m0_if.stb;
                own_we  = m0_if.we;
                own_sel = m0_if.sel;
                own_adr = m0_if.adr;
                own_dat = m0_if.dat_w;
            end
            StGnt1: begin
                own_cyc = m1_if.cyc;
                own_stb = m1_if.stb;
                own_we  = m1_if.we;
                own_sel = m1_if.sel;
                own_adr = m1_if.adr;
                own_dat = m1_if.dat_w;
            end
            default: ;
        endcase
    end

    assign s_if.cyc   = own_cyc;
    assign s_if.stb   = own_stb & ~timeout;  // withdraw the strobe on a watchdog hit
    assign s_if.we    = own_we;
    assign s_if.sel   = own_sel;
    assign s_if.adr   = own_adr;
    assign s_if.dat_w = own_dat;

    assign grant_o = {state_q == StGnt1, state_q == StGnt0};

    // Return termination and read data to the owner only; a spurious ack in
    // idle reaches nobody.
    always_comb begin
        m0_if.ack   = 1'b0;
        m0_if.err   = 1'b0;
        m0_if.dat_r = '0;
        m1_if.ack   = 1'b0;
        m1_if.err   = 1'b0;
        m1_if.dat_r = '0;
        case (state_q)
            StGnt0: begin
                m0_if.ack   = s_if.ack;
                m0_if.err   = s_if.err | timeout;
                m0_if.dat_r = s_if.dat_r;
            end
            StGnt1: begin
                m1_if.ack   = s_if.ack;
                m1_if.err   = s_if.err | timeout;
                m1_if.dat_r = s_if.dat_r;
            end
            default: ;
        endcase
    end

`ifdef AIRISC_WB_ARB_TIMEOUT_EN
    localparam logic [9:0] WdLimit = 10'(TIMEOUT);

    logic [9:0] wd_cnt_q, wd_cnt_d;

    // Count cycles the slave leaves a strobe unanswered; the hit cycle is
    // the TIMEOUT-th stalled cycle after the strobe went out.
    assign timeout = own_stb && (wd_cnt_q == WdLimit);

    // Clear on a hit, on any termination, idle strobe or owner change.
    always_comb begin
        wd_cnt_d = wd_cnt_q + 10'd1;
        if (timeout || (state_d != state_q) || !s_if.stb || s_if.ack || s_if.err) begin
            wd_cnt_d = '0;
        end
    end

    // Watchdog counter.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    logic [9:0] unused_timeout;

    assign timeout        = 1'b0;
    assign unused_timeout = 10'(TIMEOUT);
`endif

endmodule

// File: tb/tb_airisc_wb_arbiter.sv
// Testbench for airisc_wb_arbiter: cycle-vector table, directed multi-cycle
// sequences and a randomized run against a transaction-level owner model.
module tb_airisc_wb_arbiter;

    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 32;
    localparam int unsigned TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] grant;

    int checks = 0;
    int errors = 0;

    airisc_wb_arbiter_if #(.AW(AW), .DW(DW)) m0 ();
    airisc_wb_arbiter_if #(.AW(AW), .DW(DW)) m1 ();
    airisc_wb_arbiter_if #(.AW(AW), .DW(DW)) s ();

    airisc_wb_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .m0_if     (m0),
        .m1_if     (m1),
        .s_if      (s),
        .grant_o   (grant)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       m0c, m0s, m1c, m1s, ack;
        logic [1:0] gnt;
        logic       scyc, m0a, m1a;
    } vec_t;

    vec_t tbl [20];

    // randomized-run bench state
    logic        mc [2];
    logic        ms [2];
    logic        mwe [2];
    logic [3:0]  msel [2];
    logic [31:0] madr [2];
    logic [31:0] mdat [2];
    logic        done [2];
    int          owner;
    int          last;
    int          stall;

    function automatic vec_t mk(input logic [4:0] in, input logic [1:0] g,
                                input logic [2:0] out);
        vec_t v;
        {v.m0c, v.m0s, v.m1c, v.m1s, v.ack} = in;
        v.gnt = g;
        {v.scyc, v.m0a, v.m1a} = out;
        return v;
    endfunction

    task automatic check(input string nm, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [191:0] pack_dut();
        return {51'd0, s.cyc, s.stb, s.we, s.sel, s.adr, s.dat_w, grant,
                m0.ack, m0.err, m0.dat_r, m1.ack, m1.err, m1.dat_r};
    endfunction

    // Expected outputs straight from the ownership rules.
    function automatic logic [191:0] pack_exp(input int own);
        if (own == 0)
            return {51'd0, m0.cyc, m0.stb, m0.we, m0.sel, m0.adr, m0.dat_w, 2'b01,
                    s.ack, s.err, s.dat_r, 1'b0, 1'b0, 32'd0};
        if (own == 1)
            return {51'd0, m1.cyc, m1.stb, m1.we, m1.sel, m1.adr, m1.dat_w, 2'b10,
                    1'b0, 1'b0, 32'd0, s.ack, s.err, s.dat_r};
        return '0;
    endfunction

    task automatic clr_inputs();
        m0.cyc = 0; m0.stb = 0; m0.we = 0; m0.sel = '0; m0.adr = '0; m0.dat_w = '0;
        m1.cyc = 0; m1.stb = 0; m1.we = 0; m1.sel = '0; m1.adr = '0; m1.dat_w = '0;
        s.ack = 0; s.err = 0; s.dat_r = '0;
    endtask

    task automatic do_reset();
        clr_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic new_beat(input int k);
        mwe[k]  = 1'($urandom);
        msel[k] = 4'($urandom);
        madr[k] = $urandom;
        mdat[k] = $urandom;
    endtask

    // One random Wishbone master: holds a beat until it terminates.
    task automatic master_step(input int k);
        if (!mc[k]) begin
            if ($urandom_range(2) == 0) begin
                mc[k] = 1'b1; ms[k] = 1'b1; new_beat(k);
            end
        end else if (ms[k]) begin
            if (done[k]) begin
                case ($urandom_range(2))
                    0:       begin mc[k] = 1'b0; ms[k] = 1'b0; end
                    1:       new_beat(k);
                    default: ms[k] = 1'b0;
                endcase
            end
        end else begin
            if ($urandom_range(1) == 0) begin
                ms[k] = 1'b1; new_beat(k);
            end else begin
                mc[k] = 1'b0;
            end
        end
    endtask

    task automatic drive_masters();
        m0.cyc = mc[0]; m0.stb = ms[0]; m0.we = mwe[0];
        m0.sel = msel[0]; m0.adr = madr[0]; m0.dat_w = mdat[0];
        m1.cyc = mc[1]; m1.stb = ms[1]; m1.we = mwe[1];
        m1.sel = msel[1]; m1.adr = madr[1]; m1.dat_w = mdat[1];
    endtask

    initial begin
        int          ack_cnt;
        int          err_cnt;
        int          stb_low;
        logic        exp_stb;
        logic        r0, r1;
        logic [31:0] addrs [3];

        // outputs must stay zero under reset even with live requests
        clr_inputs();
        rst_n = 1'b0;
        m0.cyc = 1; m0.stb = 1; m1.cyc = 1; m1.stb = 1;
        s.ack = 1; s.dat_r = 32'hA5A5_5A5A;
        @(posedge clk);
        #1;
        check("reset_outputs", pack_dut(), '0);
        @(negedge clk);
        do_reset();

        // cycle table: contention, alternation, lock, spurious ack, idle
        tbl[0]  = mk(5'b11110, 2'b00, 3'b000);
        tbl[1]  = mk(5'b11111, 2'b01, 3'b110);
        tbl[2]  = mk(5'b00110, 2'b01, 3'b000);
        tbl[3]  = mk(5'b11111, 2'b10, 3'b101);
        tbl[4]  = mk(5'b11000, 2'b10, 3'b000);
        tbl[5]  = mk(5'b11111, 2'b01, 3'b110);
        tbl[6]  = mk(5'b00110, 2'b01, 3'b000);
        tbl[7]  = mk(5'b11111, 2'b10, 3'b101);
        tbl[8]  = mk(5'b11000, 2'b10, 3'b000);
        tbl[9]  = mk(5'b11001, 2'b01, 3'b110);
        tbl[10] = mk(5'b00000, 2'b01, 3'b000);
        tbl[11] = mk(5'b00001, 2'b00, 3'b000);
        tbl[12] = mk(5'b11110, 2'b00, 3'b000);
        tbl[13] = mk(5'b11110, 2'b10, 3'b100);
        tbl[14] = mk(5'b11100, 2'b10, 3'b100);
        tbl[15] = mk(5'b11111, 2'b10, 3'b101);
        tbl[16] = mk(5'b11001, 2'b10, 3'b001);
        tbl[17] = mk(5'b11001, 2'b01, 3'b110);
        tbl[18] = mk(5'b00000, 2'b01, 3'b000);
        tbl[19] = mk(5'b00000, 2'b00, 3'b000);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            m0.cyc = tbl[i].m0c; m0.stb = tbl[i].m0s;
            m1.cyc = tbl[i].m1c; m1.stb = tbl[i].m1s;
            s.ack  = tbl[i].ack;
            #1;
            check($sformatf("vec[%0d]", i), {grant, s.cyc, m0.ack, m1.ack},
                  {tbl[i].gnt, tbl[i].scyc, tbl[i].m0a, tbl[i].m1a});
        end

        // single write from m0, slave acks two cycles after the strobe
        @(negedge clk);
        do_reset();
        @(negedge clk);
        m0.cyc = 1; m0.stb = 1; m0.we = 1; m0.sel = 4'hF;
        m0.adr = 32'h3000_0004; m0.dat_w = 32'hDEAD_BEEF;
        #1;
        check("single_latency", {grant, s.cyc, s.stb}, 4'b0000);
        ack_cnt = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            s.ack = (c == 3);
            if (c == 4) begin m0.cyc = 0; m0.stb = 0; end
            #1;
            if (c == 1)
                check("single_bus", {s.cyc, s.stb, s.we, s.sel, s.adr, s.dat_w, grant},
                      {3'b111, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF, 2'b01});
            if (m0.ack) ack_cnt++;
            if (c == 3) check("single_grant_ack", {grant, m0.ack, m1.ack}, 4'b0110);
            if (c == 5) check("single_release", {grant, s.cyc}, 3'b000);
        end
        check("single_ack_count", 32'(ack_cnt), 32'd1);

        // lock: m1 holds cyc over three beats while m0 waits
        addrs[0] = 32'h3000_0100; addrs[1] = 32'h3000_0104; addrs[2] = 32'h3000_0108;
        do_reset();
        @(negedge clk);
        m1.cyc = 1; m1.stb = 1; m1.adr = addrs[0];
        ack_cnt = 0;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            m0.cyc = 1; m0.stb = 1;
            m1.adr = addrs[b];
            s.ack  = 1;
            #1;
            check($sformatf("lock_adr[%0d]", b), {grant, s.adr, m1.ack}, {2'b10, addrs[b], 1'b1});
            if (m0.ack) ack_cnt++;
        end
        @(negedge clk);
        m1.stb = 0; s.ack = 0;
        #1;
        if (m0.ack) ack_cnt++;
        check("lock_hold_nostb", {grant, s.cyc}, 3'b101);
        @(negedge clk);
        m1.cyc = 0;
        #1;
        if (m0.ack) ack_cnt++;
        check("lock_m0_stalled", 32'(ack_cnt), 32'd0);
        @(negedge clk);
        s.ack = 1;
        #1;
        check("lock_handover", {grant, s.cyc, m0.ack, m1.ack}, 5'b01110);

        // watchdog: silent slave
        do_reset();
        @(negedge clk);
        m0.cyc = 1; m0.stb = 1; m0.adr = 32'h3000_0200;
        @(negedge clk);
        #1;
        check("wd_stb_rise", {grant, s.stb, m0.err}, 4'b0110);
`ifdef AIRISC_WB_ARB_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("wd_cycle[%0d]", k), {m0.err, s.stb, m1.err, grant},
                  {(k == TIMEOUT), (k != TIMEOUT), 1'b0, 2'b01});
        end
`else
        err_cnt = 0;
        stb_low = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            #1;
            if (m0.err) err_cnt++;
            if (!s.stb) stb_low++;
        end
        check("wd_absent_err", 32'(err_cnt), 32'd0);
        check("wd_absent_stb", 32'(stb_low), 32'd0);
`endif

        // reset while m1 owns the bus with a strobe out
        do_reset();
        @(negedge clk);
        m1.cyc = 1; m1.stb = 1;
        @(negedge clk);
        s.ack = 1;
        #1;
        check("rst_pre", {grant, s.cyc, m1.ack}, 4'b1011);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_drop", {grant, s.cyc, s.stb, m1.ack}, 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        s.ack = 0;
        m0.cyc = 1; m0.stb = 1;
        #1;
        check("rst_after_idle", grant, 2'b00);
        @(negedge clk);
        #1;
        check("rst_after_m0_first", grant, 2'b01);

        // randomized traffic against the ownership model
        do_reset();
        for (int k = 0; k < 2; k++) begin
            mc[k] = 0; ms[k] = 0; done[k] = 0; mwe[k] = 0;
            msel[k] = '0; madr[k] = '0; mdat[k] = '0;
        end
        owner = -1;
        last  = 1;
        stall = 0;
        for (int cy = 0; cy < 3000; cy++) begin
            @(negedge clk);
            master_step(0);
            master_step(1);
            drive_masters();
            exp_stb = 1'b0;
            if (owner >= 0) exp_stb = ms[owner];
            s.ack   = 1'b0;
            s.err   = 1'b0;
            s.dat_r = $urandom;
            if (exp_stb) begin
                s.ack = (stall >= 3) || ($urandom_range(2) == 0);
                if (s.ack && $urandom_range(7) == 0) begin
                    s.ack = 1'b0; s.err = 1'b1;
                end
            end else begin
                s.ack = ($urandom_range(7) == 0);
            end
            #1;
            check($sformatf("rand[%0d]", cy), pack_dut(), pack_exp(owner));
            for (int k = 0; k < 2; k++) done[k] = ms[k] && (owner == k) && (s.ack || s.err);
            if (exp_stb && !s.ack && !s.err) stall++;
            else stall = 0;
            if (owner < 0 || !mc[owner]) begin
                r0 = mc[0] && ms[0];
                r1 = mc[1] && ms[1];
                if (r0 && r1) owner = 1 - last;
                else if (r0) owner = 0;
                else if (r1) owner = 1;
                else owner = -1;
                if (owner >= 0) last = owner;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
